// File: rtl/inst_cache.sv
// Direct-mapped instruction cache between pc_reg/if_id and the instruction
// memory bus. Lookups are combinational. A miss stalls the pipeline while a
// 4-beat line refill runs. The line is validated when the refill completes.
module inst_cache #(
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  output logic        stallreq_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  localparam int LSB   = OFFSET_W + 2;
  localparam int TAG_W = 32 - INDEX_W - LSB;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [TAG_W-1:0]      tag_lat_reg;
  logic [INDEX_W-1:0]    idx_lat_reg;
  logic [OFFSET_W-1:0]   beat_reg;
  logic                  abort_reg;
  logic [LINES-1:0]      valid_reg;

  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [31:0]           data_mem [LINES*WORDS];

  // Lookup fields of the incoming fetch address (byte offset is don't-care)
  logic [TAG_W-1:0]      lk_tag;
  logic [INDEX_W-1:0]    lk_index;
  logic [OFFSET_W-1:0]   lk_off;
  logic                  lk_hit;
  logic                  start_refill;
  logic                  fill_done;
  logic                  validate;
  logic                  unused_addr_bits;

  assign lk_tag           = rom_addr_i[31:INDEX_W+LSB];
  assign lk_index         = rom_addr_i[INDEX_W+LSB-1:LSB];
  assign lk_off           = rom_addr_i[LSB-1:2];
  assign unused_addr_bits = ^rom_addr_i[1:0];

  assign lk_hit = rom_ce_i && (state_reg == IDLE) && valid_reg[lk_index] &&
                  (tag_mem[lk_index] == lk_tag);

  // The last ack of a refill is the edge that moves REFILL into DONE
  assign fill_done = (state_reg == REFILL) && mem_ack_i && (&beat_reg);
  // A flush seen during the refill (or on its final edge) leaves the line invalid
  assign validate  = fill_done && !abort_reg && !flush_i;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic and all bus/pipeline outputs
  always_comb begin
    state_next   = state_reg;
    start_refill = 1'b0;
    rom_data_o   = '0;
    stallreq_o   = 1'b0;
    mem_req_o    = 1'b0;
    mem_addr_o   = '0;
    case (state_reg)
      IDLE: begin
        if (rom_ce_i && !lk_hit) begin
          state_next   = REFILL;
          start_refill = 1'b1;
        end
      end
      REFILL: begin
        if (mem_ack_i && (&beat_reg)) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (!rst) begin
      if (lk_hit) rom_data_o = data_mem[{lk_index, lk_off}];
      stallreq_o = (state_reg != IDLE) || (rom_ce_i && !lk_hit);
      if (state_reg == REFILL) begin
        mem_req_o  = 1'b1;
        mem_addr_o = {tag_lat_reg, idx_lat_reg, beat_reg, 2'b00};
      end
    end
  end

  // Refill bookkeeping: latched line address, beat counter, abort flag, valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_reg  <= '0;
      abort_reg <= 1'b0;
      valid_reg <= '0;
    end else begin
      if (start_refill) begin
        tag_lat_reg <= lk_tag;
        idx_lat_reg <= lk_index;
        beat_reg    <= '0;
        abort_reg   <= 1'b0;
      end
      if ((state_reg == REFILL) && mem_ack_i) beat_reg <= beat_reg + OFFSET_W'(1);
      if ((state_reg == REFILL) && flush_i) abort_reg <= 1'b1;
      if (validate) valid_reg[idx_lat_reg] <= 1'b1;
      if (flush_i) valid_reg <= '0;
    end
  end

  // Data and tag arrays: beats land as they are acked, tag written with the last beat
  always_ff @(posedge clk) begin
    if (!rst && (state_reg == REFILL) && mem_ack_i)
      data_mem[{idx_lat_reg, beat_reg}] <= mem_rdata_i;
    if (!rst && fill_done)
      tag_mem[idx_lat_reg] <= tag_lat_reg;
  end

endmodule

// File: tb/tb_inst_cache.sv
// Bench for inst_cache: directed scenarios followed by randomized fetches.
// The reference model tracks only which memory line each cache slot holds;
// the backing memory returns the word address as data, so a hit must
// always return the aligned fetch address.
module tb_inst_cache;

  localparam int DONE_FLUSH = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        stallreq_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int checks   = 0;
  int failures = 0;

  bit          m_valid [16];
  logic [23:0] m_tag   [16];

  inst_cache #(.INDEX_W(4), .OFFSET_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .stallreq_o (stallreq_o),
    .flush_i    (flush_i),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One cycle with fetch disabled; optional flush; stray acks must be ignored
  task automatic idle_cycle(input bit do_flush);
    rom_ce_i    = 1'b0;
    rom_addr_i  = $urandom;
    flush_i     = do_flush;
    mem_ack_i   = 1'($urandom_range(0, 1));
    mem_rdata_i = $urandom;
    @(negedge clk);
    chk("idle_data", rom_data_o, 32'h0);
    chk("idle_stall", {31'h0, stallreq_o}, 32'h0);
    chk("idle_req", {31'h0, mem_req_o}, 32'h0);
    next_cycle();
    if (do_flush) model_flush();
    flush_i   = 1'b0;
    mem_ack_i = 1'b0;
    $display("idle  flush=%0d", do_flush);
  endtask

  // One fetch: either a same-cycle hit, or a full miss/refill ending in IDLE
  task automatic do_fetch(input logic [31:0] addr, input int wmin, input int wmax,
                          input int flush_at, input bit wiggle);
    int          idx;
    logic [23:0] tag;
    bit          exp_hit;
    bit          aborted;
    int          rcyc;
    int          w;
    int          total_w;
    logic [31:0] line_base;
    idx       = int'(addr[7:4]);
    tag       = addr[31:8];
    line_base = {addr[31:4], 4'h0};
    exp_hit   = m_valid[idx] && (m_tag[idx] == tag);
    aborted   = 1'b0;
    rcyc      = 0;
    total_w   = 0;
    rom_ce_i    = 1'b1;
    rom_addr_i  = addr;
    flush_i     = 1'b0;
    mem_ack_i   = 1'($urandom_range(0, 1));
    mem_rdata_i = $urandom;
    @(negedge clk);
    chk("lookup_req", {31'h0, mem_req_o}, 32'h0);
    if (exp_hit) begin
      chk("hit_stall", {31'h0, stallreq_o}, 32'h0);
      chk("hit_data", rom_data_o, {addr[31:2], 2'b00});
      next_cycle();
      mem_ack_i = 1'b0;
      $display("fetch addr=0x%08h hit  data=0x%08h", addr, rom_data_o);
      return;
    end
    chk("miss_stall", {31'h0, stallreq_o}, 32'h1);
    chk("miss_data", rom_data_o, 32'h0);
    next_cycle();
    for (int b = 0; b < 4; b++) begin
      w = $urandom_range(wmax, wmin);
      total_w += w;
      for (int k = 0; k <= w; k++) begin
        mem_ack_i   = (k == w);
        mem_rdata_i = mem_ack_i ? (line_base + 32'(b * 4)) : $urandom;
        flush_i     = (rcyc == flush_at);
        if (wiggle) rom_addr_i = $urandom;
        @(negedge clk);
        chk("refill_req", {31'h0, mem_req_o}, 32'h1);
        chk("refill_addr", mem_addr_o, line_base + 32'(b * 4));
        chk("refill_stall", {31'h0, stallreq_o}, 32'h1);
        chk("refill_data", rom_data_o, 32'h0);
        if (flush_i) begin
          aborted = 1'b1;
          model_flush();
        end
        next_cycle();
        rcyc++;
      end
    end
    // DONE cycle: still stalled, bus idle, stray ack ignored
    rom_addr_i  = addr;
    mem_ack_i   = 1'($urandom_range(0, 1));
    mem_rdata_i = $urandom;
    flush_i     = (flush_at == DONE_FLUSH);
    @(negedge clk);
    chk("done_req", {31'h0, mem_req_o}, 32'h0);
    chk("done_stall", {31'h0, stallreq_o}, 32'h1);
    if (!aborted) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
    end
    if (flush_i) begin
      aborted = 1'b1;
      model_flush();
    end
    next_cycle();
    flush_i   = 1'b0;
    mem_ack_i = 1'b0;
    $display("fetch addr=0x%08h miss waits=%0d flushed=%0d", addr, total_w, aborted);
  endtask

  // Miss on addr, complete beat 0, then reset during beat 1
  task automatic reset_mid_refill(input logic [31:0] addr);
    logic [31:0] line_base;
    line_base  = {addr[31:4], 4'h0};
    rom_ce_i   = 1'b1;
    rom_addr_i = addr;
    mem_ack_i  = 1'b0;
    @(negedge clk);
    chk("rmr_miss_stall", {31'h0, stallreq_o}, 32'h1);
    next_cycle();
    mem_ack_i   = 1'b1;
    mem_rdata_i = line_base;
    @(negedge clk);
    chk("rmr_beat0_addr", mem_addr_o, line_base);
    next_cycle();
    mem_ack_i = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    chk("rmr_rst_req", {31'h0, mem_req_o}, 32'h0);
    chk("rmr_rst_stall", {31'h0, stallreq_o}, 32'h0);
    chk("rmr_rst_addr", mem_addr_o, 32'h0);
    chk("rmr_rst_data", rom_data_o, 32'h0);
    next_cycle();
    model_flush();
    rst      = 1'b0;
    rom_ce_i = 1'b0;
    @(negedge clk);
    chk("rmr_after_req", {31'h0, mem_req_o}, 32'h0);
    chk("rmr_after_stall", {31'h0, stallreq_o}, 32'h0);
    next_cycle();
    $display("reset mid-refill addr=0x%08h", addr);
  endtask

  initial begin
    logic [31:0] ra;
    int          fa;
    rst         = 1'b1;
    rom_ce_i    = 1'b1;
    rom_addr_i  = 32'h0;
    flush_i     = 1'b0;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hDEADBEEF;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end
    next_cycle();
    @(negedge clk);
    chk("rst_data", rom_data_o, 32'h0);
    chk("rst_stall", {31'h0, stallreq_o}, 32'h0);
    chk("rst_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_addr", mem_addr_o, 32'h0);
    next_cycle();
    rst       = 1'b0;
    mem_ack_i = 1'b0;
    $display("reset released");

    // Cold miss then sequential hits in the same line
    do_fetch(32'h0, 0, 0, -1, 1'b0);
    do_fetch(32'h0, 0, 0, -1, 1'b0);
    do_fetch(32'h4, 0, 0, -1, 1'b0);
    do_fetch(32'h8, 0, 0, -1, 1'b0);
    do_fetch(32'hC, 0, 0, -1, 1'b0);

    // Conflict on index 0
    do_fetch(32'h100, 0, 0, -1, 1'b0);
    do_fetch(32'h104, 0, 0, -1, 1'b0);
    do_fetch(32'h0, 0, 0, -1, 1'b0);
    do_fetch(32'h0, 0, 0, -1, 1'b0);

    // Three wait states per beat, fetch address wiggled during refill
    do_fetch(32'h20, 3, 3, -1, 1'b1);
    do_fetch(32'h2C, 0, 0, -1, 1'b0);

    // Flush during beat 2, then the same address misses again
    do_fetch(32'h40, 0, 0, 2, 1'b0);
    do_fetch(32'h40, 0, 0, -1, 1'b0);
    do_fetch(32'h44, 0, 0, -1, 1'b0);

    // Flush on the final-ack edge beats validation
    do_fetch(32'h50, 0, 0, 3, 1'b0);
    do_fetch(32'h50, 0, 0, -1, 1'b0);
    do_fetch(32'h50, 0, 0, -1, 1'b0);

    // Flush in the DONE cycle
    do_fetch(32'h60, 1, 2, DONE_FLUSH, 1'b0);
    do_fetch(32'h60, 0, 0, -1, 1'b0);

    // Idle-cycle flush drops everything
    do_fetch(32'h24, 0, 0, -1, 1'b0);
    idle_cycle(1'b1);
    do_fetch(32'h24, 0, 0, -1, 1'b0);

    // Reset in the middle of a refill
    reset_mid_refill(32'h80);
    do_fetch(32'h80, 0, 0, -1, 1'b0);
    do_fetch(32'h84, 0, 0, -1, 1'b0);

    // Randomized traffic over a few tags so conflicts are common
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle_cycle(1'($urandom_range(0, 3) == 0));
      end else begin
        ra = {22'($urandom_range(0, 2)), 4'($urandom_range(0, 15)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
        case ($urandom_range(0, 9))
          0:       fa = $urandom_range(0, 6);
          1:       fa = DONE_FLUSH;
          default: fa = -1;
        endcase
        do_fetch(ra, 0, 2, fa, 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the bench cannot hang
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inst_cache.md
INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 SHALL have parameter INDEX_W, default 4, number of index bits; the cache holds 2^INDEX_W lines.
REQ-002 SHALL have parameter OFFSET_W, fixed at 2, word-offset bits; each line is 4 words of 32 bits.
REQ-003 SHALL provide clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide rom_ce_i  input  1  fetch enable from pc_reg.
REQ-006 SHALL provide rom_addr_i  input  32  fetch byte address from pc_reg; bits [1:0] ignored.
REQ-007 SHALL provide rom_data_o  output  32  instruction word to if_id.
REQ-008 SHALL provide stallreq_o  output  1  stall request to ctrl; freezes pc_reg and if_id while high.
REQ-009 SHALL provide flush_i  input  1  invalidate all lines.
REQ-010 SHALL provide mem_req_o  output  1  refill read request to the instruction memory bus.
REQ-011 SHALL provide mem_addr_o  output  32  word-aligned refill address.
REQ-012 SHALL provide mem_ack_i  input  1  memory acknowledge; mem_rdata_i valid in the same cycle.
REQ-013 SHALL provide mem_rdata_i  input  32  refill data.

Function
REQ-014 Address split SHALL be: offset = addr[3:2], index = addr[INDEX_W+3:4], tag = addr[31:INDEX_W+4].
REQ-015 Storage SHALL be: per line, one valid bit, one tag, and 4 data words; direct-mapped.
REQ-016 Hit SHALL mean rom_ce_i=1, state IDLE, line valid, and stored tag equal to the address tag.
REQ-017 On hit, rom_data_o SHALL equal the addressed word combinationally in the same cycle, and stallreq_o SHALL be 0.
REQ-018 With rom_ce_i=0, rom_data_o SHALL be 0, stallreq_o SHALL be 0, and no refill SHALL start.
REQ-019 On miss in IDLE, stallreq_o SHALL be 1 combinationally, and the FSM SHALL latch {tag,index} and enter REFILL next edge.
REQ-020 FSM states SHALL be IDLE, REFILL, and DONE; REFILL->DONE after the 4th ack; DONE->IDLE unconditionally after one cycle.
REQ-021 In REFILL, mem_req_o SHALL be 1 and mem_addr_o SHALL be {latched tag, latched index, beat counter, 2'b00}; the beat counter SHALL run 0..3 starting at 0.
REQ-022 mem_addr_o SHALL stay stable while mem_req_o=1 and mem_ack_i=0; wait states SHALL be unbounded.
REQ-023 On an edge with mem_ack_i=1 in REFILL, mem_rdata_i SHALL be written to the current beat word, and the counter SHALL increment (wrapping 3->0).
REQ-024 mem_req_o SHALL remain 1 back-to-back across beats; it SHALL be 0 in IDLE and DONE.
REQ-025 On entry to DONE, the line SHALL be written valid with the latched tag, overwriting any previous occupant.
REQ-026 stallreq_o SHALL be 1 throughout REFILL and DONE; in the first IDLE cycle after DONE, the lookup SHALL be re-evaluated and hit.
REQ-027 mem_ack_i SHALL be ignored outside REFILL.
REQ-028 A rom_addr_i change during REFILL SHALL NOT alter the refill in progress.
REQ-029 flush_i=1 SHALL clear all valid bits at the next edge in any state.
REQ-030 If flush_i=1 occurs in REFILL or DONE, the refill SHALL run to completion for bus integrity, but the line SHALL NOT be set valid.
REQ-031 If flush_i=1 and a DONE validation fall on the same edge, flush SHALL win.
REQ-032 Miss latency SHALL be 4 + total wait cycles + 2 cycles from miss detection to hit.

Reset
REQ-033 When rst=1 at an edge, state SHALL become IDLE, the counter 0, and all valid bits 0; data and tag arrays need not reset.
REQ-034 While rst=1, rom_data_o SHALL be 0, stallreq_o 0, mem_req_o 0, and mem_addr_o 0.
REQ-035 Reset mid-REFILL SHALL drop mem_req_o at that edge and discard the partial line.

Verification
REQ-036 Cold miss: rst released, rom_ce_i=1, addr 0x00000000, ack every cycle, memory word = address -> stallreq_o high 6 cycles, requests to 0x0,0x4,0x8,0xC, then rom_data_o=0x00000000 with stallreq_o=0.
REQ-037 Sequential hits: after REQ-036, addr 0x4, 0x8, 0xC -> data 0x4, 0x8, 0xC each same cycle, no mem_req_o.
REQ-038 Conflict: addr 0x00000100 (same index 0, new tag) -> refill; then 0x0 misses again and refills.
REQ-039 Wait states: ack delayed 3 cycles per beat on addr 0x20 -> mem_addr_o held each wait, stall = 4*4+2 cycles.
REQ-040 Flush mid-refill: flush_i pulse during beat 2 -> all 4 beats complete, the line is not valid, and the same address misses again.
REQ-041 Reset mid-refill: rst during beat 1 -> mem_req_o=0 next cycle, stallreq_o=0, and the subsequent fetch of the same address misses.
